// File: rtl/pong_match_sequencer.sv
// Pong match FSM: idle/serve/play/point/pause/game-over, scoring, tick gating and round reset.
// Latency: all outputs registered (1 cycle); buttons reach the state 3 cycles after the pin rises; no backpressure.
module pong_match_sequencer #(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_TICKS = 7,
  parameter int SCORE_W     = 3
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic               game_tick,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic               lossA,
  input  logic               lossB,
  output logic               tick_en,
  output logic               round_reset,
  output logic [SCORE_W-1:0] scoreA,
  output logic [SCORE_W-1:0] scoreB,
  output logic               point_pulse,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  localparam int CNT_W = $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(SERVE_TICKS);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_PAUSED   = 3'd4,
    S_GAMEOVER = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic [SCORE_W-1:0] score_new;
  logic [1:0]         winner_q, winner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               scorer_b_q, scorer_b_d;
  logic               tick_en_q, tick_en_d;
  logic               round_reset_q, round_reset_d;
  logic               point_pulse_q, point_pulse_d;
  logic [2:0]         start_sync_q, pause_sync_q;
  logic               start_ev, pause_ev;

  // bit0/bit1 synchronize, bit2 remembers the previous synced level for edge detection
  assign start_ev = start_sync_q[1] & ~start_sync_q[2];
  assign pause_ev = pause_sync_q[1] & ~pause_sync_q[2];

  always_comb begin
    state_d    = state_q;
    score_a_d  = score_a_q;
    score_b_d  = score_b_q;
    winner_d   = winner_q;
    cnt_d      = cnt_q;
    scorer_b_d = scorer_b_q;
    score_new  = '0;

    case (state_q)
      S_IDLE: begin
        if (start_ev) begin
          state_d   = S_SERVE;
          score_a_d = '0;
          score_b_d = '0;
          cnt_d     = CNT_LOAD;
        end
      end
      S_SERVE: begin
        if (game_tick) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (lossA && lossB) begin
          state_d = S_SERVE;
          cnt_d   = CNT_LOAD;
        end else if (lossA) begin
          state_d    = S_POINT;
          scorer_b_d = 1'b1;
        end else if (lossB) begin
          state_d    = S_POINT;
          scorer_b_d = 1'b0;
        end else if (pause_ev) begin
          state_d = S_PAUSED;
        end
      end
      S_POINT: begin
        if (scorer_b_q) begin
          score_new = (score_b_q == SCORE_MAX) ? score_b_q : score_b_q + SCORE_W'(1);
          score_b_d = score_new;
        end else begin
          score_new = (score_a_q == SCORE_MAX) ? score_a_q : score_a_q + SCORE_W'(1);
          score_a_d = score_new;
        end
        if (score_new == WIN_VAL) begin
          state_d  = S_GAMEOVER;
          winner_d = scorer_b_q ? 2'b10 : 2'b01;
        end else begin
          state_d = S_SERVE;
          cnt_d   = CNT_LOAD;
        end
      end
      S_PAUSED: begin
        if (pause_ev) state_d = S_PLAY;
      end
      S_GAMEOVER: begin
        if (start_ev) begin
          state_d   = S_SERVE;
          score_a_d = '0;
          score_b_d = '0;
          winner_d  = 2'b00;
          cnt_d     = CNT_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // decoded from the next state so round_reset lines up with the visible state
    round_reset_d = !((state_d == S_PLAY) || (state_d == S_PAUSED));
    tick_en_d     = game_tick && (state_q == S_PLAY);
    point_pulse_d = (state_q == S_POINT);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      score_a_q     <= '0;
      score_b_q     <= '0;
      winner_q      <= 2'b00;
      cnt_q         <= '0;
      scorer_b_q    <= 1'b0;
      tick_en_q     <= 1'b0;
      round_reset_q <= 1'b1;
      point_pulse_q <= 1'b0;
      start_sync_q  <= '0;
      pause_sync_q  <= '0;
    end else begin
      state_q       <= state_d;
      score_a_q     <= score_a_d;
      score_b_q     <= score_b_d;
      winner_q      <= winner_d;
      cnt_q         <= cnt_d;
      scorer_b_q    <= scorer_b_d;
      tick_en_q     <= tick_en_d;
      round_reset_q <= round_reset_d;
      point_pulse_q <= point_pulse_d;
      start_sync_q  <= {start_sync_q[1:0], start_btn};
      pause_sync_q  <= {pause_sync_q[1:0], pause_btn};
    end
  end

  assign tick_en     = tick_en_q;
  assign round_reset = round_reset_q;
  assign scoreA      = score_a_q;
  assign scoreB      = score_b_q;
  assign point_pulse = point_pulse_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule
